add_accumulator: RTL and testbench
==================================

// Module: add_accumulator
// PURPOSE
//   Downstream stage of the 5-bit ripple adder: takes each {Cout,S} result as a 6-bit operand,
//   accumulates MAX_CNT operands into an ACC_W-bit total and presents the total with valid/ready.
//   A frame starts on a start pulse. The stage provides per-frame summation with sticky overflow
//   for the lab datapath.
// PARAMETERS
//   IN_W     5    sum width from adder stage; operand width is IN_W+1 (carry prepended)
//   ACC_W    10   accumulator width; must be >= IN_W+1
//   MAX_CNT  8    operands per frame; must be >= 1
//   CNT_W    4    counter width; 2**CNT_W must be > MAX_CNT
// PORTS
//   clk        in   1        clock; all state updates on rising edge
//   rst_n      in   1        synchronous active-low reset
//   start      in   1        frame start pulse
//   in_valid   in   1        adder result valid
//   in_ready   out  1        stage accepts an operand this cycle
//   S          in   IN_W     adder sum bits
//   Cout       in   1        adder carry out
//   out_valid  out  1        frame total available
//   out_ready  in   1        consumer takes total
//   acc_out    out  ACC_W    accumulator register (meaningful when out_valid=1)
//   ovf        out  1        sticky: frame total exceeded 2**ACC_W-1
//   busy       out  1        high in ACCUM and HOLD
//   count      out  CNT_W    operands accepted in current frame
// BEHAVIOUR
//   - Reset (rst_n=0 at clk edge): state=IDLE; acc_out=0, count=0, ovf=0, out_valid=0, in_ready=0, busy=0.
//     Reset overrides every other input, including mid-frame; any partial frame is discarded.
//   - Operand op = {Cout,S}, zero-extended to ACC_W. Range is 0..2**(IN_W+1)-1; default 0..63.
//   - States, encoded 2 bits:
//     IDLE : in_ready=0, out_valid=0. start=1 -> ACCUM; clear acc, count and ovf.
//     ACCUM: in_ready=1. Beat = in_valid&in_ready.
//            On a beat: acc<=acc+op (ACC_W+1-bit sum; the low ACC_W bits are kept and wrap);
//            ovf<=ovf|carry; count<=count+1.
//            If count==MAX_CNT-1 on a beat -> HOLD.
//            start=1 in ACCUM restarts the frame: clear acc, count and ovf, stay in ACCUM.
//            A beat in the same cycle as start is discarded, not summed.
//     HOLD : in_ready=0, out_valid=1; acc_out, ovf and count held stable.
//            out_ready=1 -> IDLE. If start=1 in the same cycle -> ACCUM with cleared state (back-to-back frames).
//            start=1 without out_ready is ignored.
//   - Latency: acc_out reflects a beat 1 cycle after that beat.
//     out_valid rises the cycle after the MAX_CNT-th beat.
//   - in_ready is a function of state only; no combinational path from in_valid.
//     out_valid is registered, with no path from out_ready.
//   - in_valid while in_ready=0 is dropped. The upstream stage must hold its data until a beat occurs.
//   - MAX_CNT=1: a single beat goes ACCUM -> HOLD.
//   - count equals MAX_CNT in HOLD and is cleared on entry to ACCUM.
// STRUCTURE
//   - add_acc_defs.vh (shared include): state localparams ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_HOLD=2'd2.
//     ST_HOLD also serves the out_valid decode. Any unused encoding returns to IDLE.
//   - One sub-module, ripple_add_n #(W): a W-bit ripple-carry adder built from the existing 1-bit adder cell.
//     Instantiated once with W=ACC_W for acc+op; its carry-out feeds ovf.
//   - Top level: FSM, acc/count/ovf registers and the handshake decode only.
// TESTING
//   1 Reset: hold rst_n=0 for 2 clocks mid-frame -> every output 0, IDLE; next start begins a clean frame.
//   2 Defaults: start, then 8 beats of {Cout,S}={0,5'd3}..{1,5'd31}, sum 263.
//     -> out_valid 1 cycle after beat 8; acc_out=263, ovf=0, count=8.
//   3 Overflow with ACC_W=8: 5 beats of op=63 -> acc_out=315 mod 256=59, ovf=1, held in HOLD until out_ready.
//   4 Backpressure: in_valid toggles randomly -> only in_ready&in_valid beats summed.
//     Stall out_ready for 4 cycles in HOLD -> acc_out stable, in_ready=0.
//   5 Restart: start with a beat on the 3rd operand -> that beat is discarded; count=0 next cycle; the frame completes normally.
//   6 Back-to-back: out_ready&start in HOLD -> ACCUM next cycle, acc=0, ovf=0; the second frame total is correct.

Source files
------------

// File: rtl/add_accumulator_pkg.sv
// Shared state encoding for the add_accumulator slice.
// Encoding 2'd3 is unused and recovers to ST_IDLE.
package add_accumulator_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;
endpackage

// File: rtl/add_accumulator_ripple_add_n.sv
// W-bit ripple-carry adder chained from 1-bit full_adder cells.
// Purely combinational, no backpressure.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module ripple_add_n #(
  parameter int W = 10
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  logic [W:0] c;

  assign c[0] = cin;
  assign cout = c[W];

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .s   (s[i]),
      .cout(c[i+1])
    );
  end
endmodule

// File: rtl/add_accumulator.sv
// Sums MAX_CNT {Cout,S} operands per frame with sticky overflow; total valid 1 cycle after last beat.
// in_ready/out_valid are registered state decodes; total held in HOLD until out_ready.
module add_accumulator
  import add_accumulator_pkg::*;
#(
  parameter int IN_W    = 5,
  parameter int ACC_W   = 10,
  parameter int MAX_CNT = 8,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  S,
  input  logic             Cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic             busy,
  output logic [CNT_W-1:0] count
);
  state_t           state;
  logic [ACC_W-1:0] op;
  logic [ACC_W-1:0] sum;
  logic             carry;
  logic             beat;

  assign op   = ACC_W'({Cout, S});
  assign beat = in_valid & in_ready;

  ripple_add_n #(.W(ACC_W)) u_add (
    .a   (acc_out),
    .b   (op),
    .cin (1'b0),
    .s   (sum),
    .cout(carry)
  );

  // Outputs are written together with the state so they always match its decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc_out   <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_ACCUM;
            acc_out  <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (start) begin
            // Restart wins over a coincident beat; that operand is discarded.
            acc_out <= '0;
            count   <= '0;
            ovf     <= 1'b0;
          end else if (beat) begin
            acc_out <= sum;
            ovf     <= ovf | carry;
            count   <= count + 1'b1;
            if (count == CNT_W'(MAX_CNT - 1)) begin
              state     <= ST_HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (start) begin
              state    <= ST_ACCUM;
              acc_out  <= '0;
              count    <= '0;
              ovf      <= 1'b0;
              in_ready <= 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_add_accumulator.sv
// Directed bench: default instance, ACC_W=8/MAX_CNT=5 instance, MAX_CNT=1 instance on shared inputs.
module tb_add_accumulator;
  logic       clk = 1'b0;
  logic       rst_n, start, in_valid, out_ready, Cout;
  logic [4:0] S;

  logic       rdy_a, vld_a, ovf_a, busy_a;
  logic [9:0] acc_a;
  logic [3:0] cnt_a;
  logic       rdy_b, vld_b, ovf_b, busy_b;
  logic [7:0] acc_b;
  logic [3:0] cnt_b;
  logic       rdy_c, vld_c, ovf_c, busy_c;
  logic [9:0] acc_c;
  logic [3:0] cnt_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  add_accumulator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy_a),
    .S(S), .Cout(Cout), .out_valid(vld_a), .out_ready(out_ready), .acc_out(acc_a),
    .ovf(ovf_a), .busy(busy_a), .count(cnt_a)
  );

  add_accumulator #(.ACC_W(8), .MAX_CNT(5)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy_b),
    .S(S), .Cout(Cout), .out_valid(vld_b), .out_ready(out_ready), .acc_out(acc_b),
    .ovf(ovf_b), .busy(busy_b), .count(cnt_b)
  );

  add_accumulator #(.MAX_CNT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy_c),
    .S(S), .Cout(Cout), .out_valid(vld_c), .out_ready(out_ready), .acc_out(acc_c),
    .ovf(ovf_c), .busy(busy_c), .count(cnt_c)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int v);
    {Cout, S} = 6'(v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; set_op(0);
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({acc_a, cnt_a, ovf_a, vld_a, rdy_a, busy_a} !== 18'd0) begin
      errors++; $display("FAIL reset_init: got acc=%0d cnt=%0d ovf=%b vld=%b rdy=%b busy=%b want all 0",
                         acc_a, cnt_a, ovf_a, vld_a, rdy_a, busy_a); end
    start = 1'b1; cyc(); start = 1'b0;
    in_valid = 1'b1; set_op(9); cyc(); cyc();
    checks++; if (acc_a !== 10'd18 || cnt_a !== 4'd2) begin
      errors++; $display("FAIL reset_prefill: got acc=%0d cnt=%0d want 18/2", acc_a, cnt_a); end
    rst_n = 1'b0; cyc(); cyc();
    checks++; if ({acc_a, cnt_a, ovf_a, vld_a, rdy_a, busy_a} !== 18'd0) begin
      errors++; $display("FAIL reset_midframe: got acc=%0d cnt=%0d ovf=%b vld=%b rdy=%b busy=%b want all 0",
                         acc_a, cnt_a, ovf_a, vld_a, rdy_a, busy_a); end
    rst_n = 1'b1; in_valid = 1'b1; cyc();
    checks++; if (rdy_a !== 1'b0 || cnt_a !== 4'd0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL reset_idle_drop: got rdy=%b cnt=%0d busy=%b want 0/0/0", rdy_a, cnt_a, busy_a); end
    in_valid = 1'b0; start = 1'b1; cyc(); start = 1'b0;
    in_valid = 1'b1; set_op(1); cyc();
    checks++; if (vld_c !== 1'b1 || acc_c !== 10'd1 || cnt_c !== 4'd1 || rdy_c !== 1'b0) begin
      errors++; $display("FAIL maxcnt1_hold: got vld=%b acc=%0d cnt=%0d rdy=%b want 1/1/1/0",
                         vld_c, acc_c, cnt_c, rdy_c); end
    for (int i = 0; i < 7; i++) cyc();
    in_valid = 1'b0;
    checks++; if (vld_a !== 1'b1 || acc_a !== 10'd8 || cnt_a !== 4'd8 || acc_c !== 10'd1) begin
      errors++; $display("FAIL reset_clean_frame: got vld=%b acc=%0d cnt=%0d acc1=%0d want 1/8/8/1",
                         vld_a, acc_a, cnt_a, acc_c); end
    out_ready = 1'b1; cyc(); out_ready = 1'b0;
  endtask

  task automatic test_defaults();
    int ops [8] = '{3, 10, 20, 33, 40, 50, 44, 63};
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    checks++; if (rdy_a !== 1'b1 || busy_a !== 1'b1 || cnt_a !== 4'd0) begin
      errors++; $display("FAIL defaults_enter: got rdy=%b busy=%b cnt=%0d want 1/1/0", rdy_a, busy_a, cnt_a); end
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_op(ops[i]); cyc();
      if (i == 0) begin
        checks++; if (acc_a !== 10'd3 || cnt_a !== 4'd1) begin
          errors++; $display("FAIL defaults_first_beat: got acc=%0d cnt=%0d want 3/1", acc_a, cnt_a); end
      end
      if (i == 6) begin
        checks++; if (vld_a !== 1'b0 || acc_a !== 10'd200) begin
          errors++; $display("FAIL defaults_beat7: got vld=%b acc=%0d want 0/200", vld_a, acc_a); end
      end
    end
    in_valid = 1'b0;
    checks++; if (vld_a !== 1'b1 || acc_a !== 10'd263 || ovf_a !== 1'b0 || cnt_a !== 4'd8 || rdy_a !== 1'b0) begin
      errors++; $display("FAIL defaults_total: got vld=%b acc=%0d ovf=%b cnt=%0d rdy=%b want 1/263/0/8/0",
                         vld_a, acc_a, ovf_a, cnt_a, rdy_a); end
    out_ready = 1'b1; cyc(); out_ready = 1'b0;
    checks++; if (vld_a !== 1'b0 || busy_a !== 1'b0 || rdy_a !== 1'b0) begin
      errors++; $display("FAIL defaults_release: got vld=%b busy=%b rdy=%b want 0/0/0", vld_a, busy_a, rdy_a); end
  endtask

  task automatic test_overflow();
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    in_valid = 1'b1; set_op(63);
    for (int i = 0; i < 4; i++) cyc();
    checks++; if (ovf_b !== 1'b0 || acc_b !== 8'd252) begin
      errors++; $display("FAIL ovf_before: got ovf=%b acc=%0d want 0/252", ovf_b, acc_b); end
    cyc(); in_valid = 1'b0;
    checks++; if (vld_b !== 1'b1 || acc_b !== 8'd59 || ovf_b !== 1'b1 || cnt_b !== 4'd5) begin
      errors++; $display("FAIL ovf_total: got vld=%b acc=%0d ovf=%b cnt=%0d want 1/59/1/5",
                         vld_b, acc_b, ovf_b, cnt_b); end
    start = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    start = 1'b0; in_valid = 1'b0;
    checks++; if (vld_b !== 1'b1 || acc_b !== 8'd59 || ovf_b !== 1'b1 || cnt_b !== 4'd5 || rdy_b !== 1'b0) begin
      errors++; $display("FAIL ovf_hold: got vld=%b acc=%0d ovf=%b cnt=%0d rdy=%b want 1/59/1/5/0",
                         vld_b, acc_b, ovf_b, cnt_b, rdy_b); end
    out_ready = 1'b1; cyc(); out_ready = 1'b0;
    checks++; if (vld_b !== 1'b0 || busy_b !== 1'b0) begin
      errors++; $display("FAIL ovf_release: got vld=%b busy=%b want 0/0", vld_b, busy_b); end
  endtask

  task automatic test_backpressure();
    logic [11:0] pat = 12'b1111_0101_1001;
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    // Valid pattern LSB first; ops i*5+1 on valid cycles sum to 263.
    for (int i = 0; i < 12; i++) begin
      in_valid = pat[i]; set_op(i * 5 + 1); cyc();
      if (i == 5) begin
        checks++; if (cnt_a !== 4'd3 || acc_a !== 10'd38) begin
          errors++; $display("FAIL bp_partial: got cnt=%0d acc=%0d want 3/38", cnt_a, acc_a); end
      end
    end
    checks++; if (vld_a !== 1'b1 || acc_a !== 10'd263 || cnt_a !== 4'd8) begin
      errors++; $display("FAIL bp_total: got vld=%b acc=%0d cnt=%0d want 1/263/8", vld_a, acc_a, cnt_a); end
    in_valid = 1'b1; set_op(63);
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if (acc_a !== 10'd263 || rdy_a !== 1'b0 || vld_a !== 1'b1 || cnt_a !== 4'd8) begin
        errors++; $display("FAIL bp_stall%0d: got acc=%0d rdy=%b vld=%b cnt=%0d want 263/0/1/8",
                           i, acc_a, rdy_a, vld_a, cnt_a); end
    end
    in_valid = 1'b0; out_ready = 1'b1; cyc(); out_ready = 1'b0;
  endtask

  task automatic test_restart();
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    in_valid = 1'b1; set_op(10); cyc(); set_op(20); cyc();
    start = 1'b1; set_op(30); cyc(); start = 1'b0; in_valid = 1'b0;
    checks++; if (cnt_a !== 4'd0 || acc_a !== 10'd0 || rdy_a !== 1'b1 || ovf_a !== 1'b0) begin
      errors++; $display("FAIL restart_clear: got cnt=%0d acc=%0d rdy=%b ovf=%b want 0/0/1/0",
                         cnt_a, acc_a, rdy_a, ovf_a); end
    in_valid = 1'b1; set_op(7);
    for (int i = 0; i < 8; i++) cyc();
    in_valid = 1'b0;
    checks++; if (vld_a !== 1'b1 || acc_a !== 10'd56 || cnt_a !== 4'd8) begin
      errors++; $display("FAIL restart_total: got vld=%b acc=%0d cnt=%0d want 1/56/8", vld_a, acc_a, cnt_a); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    in_valid = 1'b1; set_op(63);
    for (int i = 0; i < 8; i++) cyc();
    in_valid = 1'b0;
    checks++; if (vld_a !== 1'b1 || acc_a !== 10'd504 || ovf_a !== 1'b0 || vld_b !== 1'b1 || ovf_b !== 1'b1) begin
      errors++; $display("FAIL b2b_first: got vld=%b acc=%0d ovf=%b vld8=%b ovf8=%b want 1/504/0/1/1",
                         vld_a, acc_a, ovf_a, vld_b, ovf_b); end
    out_ready = 1'b1; start = 1'b1; cyc(); out_ready = 1'b0; start = 1'b0;
    checks++; if (rdy_a !== 1'b1 || vld_a !== 1'b0 || acc_a !== 10'd0 || cnt_a !== 4'd0 ||
                  rdy_b !== 1'b1 || ovf_b !== 1'b0 || acc_b !== 8'd0) begin
      errors++; $display("FAIL b2b_reenter: got rdy=%b vld=%b acc=%0d cnt=%0d rdy8=%b ovf8=%b acc8=%0d want 1/0/0/0/1/0/0",
                         rdy_a, vld_a, acc_a, cnt_a, rdy_b, ovf_b, acc_b); end
    in_valid = 1'b1; set_op(20);
    for (int i = 0; i < 8; i++) cyc();
    in_valid = 1'b0;
    checks++; if (vld_a !== 1'b1 || acc_a !== 10'd160 || ovf_a !== 1'b0 || cnt_a !== 4'd8) begin
      errors++; $display("FAIL b2b_second: got vld=%b acc=%0d ovf=%b cnt=%0d want 1/160/0/8",
                         vld_a, acc_a, ovf_a, cnt_a); end
    checks++; if (vld_b !== 1'b1 || acc_b !== 8'd100 || ovf_b !== 1'b0) begin
      errors++; $display("FAIL b2b_second8: got vld=%b acc=%0d ovf=%b want 1/100/0", vld_b, acc_b, ovf_b); end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_overflow();
    test_backpressure();
    test_restart();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
